// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
// Shared types and helpers for the player-life bookkeeping logic.
//   life_state_t  : ALIVE / INVULN / GAME_OVER
//   HEART_COUNT   : number of hearts drawn by the HUD life sprite
//   thermometer() : life count -> heart fill mask (bit0 = heart_1)
// Optional feature macro used by the consumers of this package: LIFE_BLINK_EN
// -----------------------------------------------------------------------------
package life_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        INVULN    = 2'd1,
        GAME_OVER = 2'd2
    } life_state_t;

    localparam int unsigned HEART_COUNT   = 3;
    localparam int unsigned BLINK_FRAMES  = 8;

    // Fill the lowest 'lives' hearts.
    function automatic logic [2:0] thermometer(input logic [1:0] lives);
        logic [2:0] mask;
        case (lives)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = 3'b011;
            2'd3:    mask = 3'b111;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Turns the level vertical-sync input into a one-cycle frame tick on its
// rising edge. Shared by all frame-synchronous game logic.
// Ports:
//   i_clk    in  clock
//   i_rst    in  synchronous reset, active-high (clears the delayed v_sync)
//   i_v_sync in  vertical sync level
//   o_tick   out 1-cycle pulse on the rising edge of i_v_sync
// -----------------------------------------------------------------------------
module frame_tick_gen (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_v_sync,
    output logic o_tick
);

    logic r_v_sync_q;

    // Delay v_sync by one clock for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v_sync_q <= 1'b0;
        end else begin
            r_v_sync_q <= i_v_sync;
        end
    end

    assign o_tick = i_v_sync & ~r_v_sync_q;

endmodule

// File: rtl/life_controller.sv
// -----------------------------------------------------------------------------
// life_controller
// Player-life bookkeeping for the HUD life sprite. Counts lives, applies hit
// and extra-life events once per frame, runs a frame-counted invulnerability
// window and produces the 3-heart fill mask. All visible state changes only
// on frame ticks (rising i_v_sync) so the HUD never tears mid-frame; restart
// and reset act immediately.
// Ports:
//   i_clk         in  clock
//   i_rst         in  synchronous reset, active-high
//   i_v_sync      in  vertical sync level; rising edge = frame tick
//   i_hit         in  1-cycle pulse, player damaged
//   i_extra_life  in  1-cycle pulse, life pickup
//   i_restart     in  1-cycle pulse, new game
//   o_lives       out current life count
//   o_heart_full  out heart fill mask, bit0 = heart_1
//   o_invuln      out high while invulnerable
//   o_game_over   out high while game over
//   o_life_lost   out 1-cycle pulse after the tick that removed a life
// Optional feature: LIFE_BLINK_EN -- during invulnerability the most recently
// lost heart blinks with a BLINK_FRAMES half-period, starting filled.
// -----------------------------------------------------------------------------
module life_controller
    import life_pkg::*;
#(
    parameter int unsigned MAX_LIVES     = 3,
    parameter int unsigned INVULN_FRAMES = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_v_sync,
    input  logic       i_hit,
    input  logic       i_extra_life,
    input  logic       i_restart,
    output logic [1:0] o_lives,
    output logic [2:0] o_heart_full,
    output logic       o_invuln,
    output logic       o_game_over,
    output logic       o_life_lost
);

    localparam logic [1:0] MAX_L    = 2'(MAX_LIVES);
    localparam logic [7:0] INV_LOAD = 8'(INVULN_FRAMES - 1);

    logic                   w_tick;
    logic                   w_hit;
    logic                   w_extra;

    life_state_t            r_state;
    logic [1:0]             r_lives;
    logic [7:0]             r_inv_cnt;
    logic                   r_pend_hit;
    logic                   r_pend_extra;
    logic [HEART_COUNT-1:0] r_heart_full;
    logic                   r_invuln;
    logic                   r_game_over;
    logic                   r_life_lost;

    life_state_t            w_state_nxt;
    logic [1:0]             w_lives_ext;
    logic [1:0]             w_lives_nxt;
    logic [7:0]             w_cnt_nxt;
    logic                   w_lost_nxt;
    logic [HEART_COUNT-1:0] w_heart_nxt;

    frame_tick_gen u_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_v_sync (i_v_sync),
        .o_tick   (w_tick)
    );

    // A pulse arriving on the tick cycle itself belongs to that tick.
    assign w_hit   = r_pend_hit   | i_hit;
    assign w_extra = r_pend_extra | i_extra_life;

    // Next-frame life state: extra life is applied before the hit.
    always_comb begin
        w_lives_ext = r_lives;
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_cnt_nxt   = r_inv_cnt;
        w_lost_nxt  = 1'b0;

        if (w_extra && (r_state != GAME_OVER) && (r_lives < MAX_L)) begin
            w_lives_ext = r_lives + 2'd1;
        end else begin
            w_lives_ext = r_lives;
        end
        w_lives_nxt = w_lives_ext;

        case (r_state)
            ALIVE: begin
                if (w_hit) begin
                    w_lost_nxt = 1'b1;
                    if (w_lives_ext <= 2'd1) begin
                        w_lives_nxt = 2'd0;
                        w_state_nxt = GAME_OVER;
                    end else begin
                        w_lives_nxt = w_lives_ext - 2'd1;
                        w_state_nxt = INVULN;
                        w_cnt_nxt   = INV_LOAD;
                    end
                end else begin
                    w_state_nxt = ALIVE;
                end
            end
            INVULN: begin
                // Hits are ignored while invulnerable.
                if (r_inv_cnt == 8'd0) begin
                    w_state_nxt = ALIVE;
                end else begin
                    w_cnt_nxt   = r_inv_cnt - 8'd1;
                end
            end
            GAME_OVER: begin
                w_lives_nxt = 2'd0;
                w_state_nxt = GAME_OVER;
            end
            default: begin
                w_lives_nxt = 2'd0;
                w_state_nxt = GAME_OVER;
            end
        endcase
    end

`ifdef LIFE_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] r_blink_cnt;
    logic       r_blink_on;
    logic [7:0] w_blink_cnt_nxt;
    logic       w_blink_on_nxt;
    logic [3:0] w_blink_bit;

    // Blink phase: restart "filled" on INVULN entry, toggle every BLINK_FRAMES.
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;
        if (r_state != INVULN) begin
            w_blink_cnt_nxt = 8'd0;
            w_blink_on_nxt  = 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_nxt = 8'd0;
            w_blink_on_nxt  = ~r_blink_on;
        end else begin
            w_blink_cnt_nxt = r_blink_cnt + 8'd1;
        end

        // Heart at index lives is the one just lost; 4 bits so lives=3 drops out.
        w_blink_bit = 4'b0001 << w_lives_nxt;
        if ((w_state_nxt == INVULN) && w_blink_on_nxt) begin
            w_heart_nxt = thermometer(w_lives_nxt) | w_blink_bit[2:0];
        end else begin
            w_heart_nxt = thermometer(w_lives_nxt);
        end
    end

    // Blink phase registers, advanced on frame ticks only.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_blink_cnt <= 8'd0;
            r_blink_on  <= 1'b0;
        end else if (w_tick) begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
        end else begin
            r_blink_cnt <= r_blink_cnt;
            r_blink_on  <= r_blink_on;
        end
    end
`else
    // Plain heart mask straight from the life count.
    always_comb begin
        w_heart_nxt = thermometer(w_lives_nxt);
    end
`endif

    // Life state, pending events and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            r_state      <= ALIVE;
            r_lives      <= MAX_L;
            r_inv_cnt    <= 8'd0;
            r_pend_hit   <= 1'b0;
            r_pend_extra <= 1'b0;
            r_heart_full <= thermometer(MAX_L);
            r_invuln     <= 1'b0;
            r_game_over  <= 1'b0;
            r_life_lost  <= 1'b0;
        end else if (w_tick) begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_inv_cnt    <= w_cnt_nxt;
            r_pend_hit   <= 1'b0;
            r_pend_extra <= 1'b0;
            r_heart_full <= w_heart_nxt;
            r_invuln     <= (w_state_nxt == INVULN);
            r_game_over  <= (w_state_nxt == GAME_OVER);
            r_life_lost  <= w_lost_nxt;
        end else begin
            r_pend_hit   <= w_hit;
            r_pend_extra <= w_extra;
            r_life_lost  <= 1'b0;
        end
    end

    assign o_lives      = r_lives;
    assign o_heart_full = r_heart_full;
    assign o_invuln     = r_invuln;
    assign o_game_over  = r_game_over;
    assign o_life_lost  = r_life_lost;

endmodule
